store_narrow: RTL and testbench

STORE_NARROW -- requirements
Module: store_narrow

---
 rtl/store_narrow.sv | 218 +++++++++++++++++++++
 tb/tb_store_narrow.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_narrow.sv
// -----------------------------------------------------------------------------
// store_narrow
//   Store buffer that narrows byte/halfword/word stores into word-aligned,
//   lane-replicated write data with byte enables, and queues them in a
//   DEPTH-entry FIFO towards the memory side.
//
// Configuration macro:
//   STORE_MISALIGN_TRAP_EN  when defined, misaligned stores are accepted but
//                           not enqueued; a one-cycle misalign pulse follows
//                           and misalign_addr captures the offending address.
//                           When undefined, misaligned addresses are rounded
//                           down to the access size and enqueued normally.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready = !full)
//   in_addr/in_data     byte address and register data of the store
//   in_size             00 byte, 01 halfword, 10 word, 11 reserved
//   flush               synchronous discard of every buffered entry
//   out_valid/out_ready head-entry handshake towards memory
//   out_addr            word-aligned address of the head entry
//   out_wdata/out_be    lane-aligned write data and byte enables
//   misalign            one-cycle pulse after a trapped store
//   misalign_addr       in_addr of the last trapped store
// -----------------------------------------------------------------------------
module store_narrow #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_size,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_wdata,
    output logic [3:0]  out_be,
    output logic        misalign,
    output logic [31:0] misalign_addr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
    } lane_fmt_t;

    // Replicate the store data across lanes and derive byte enables.
    // Reserved size falls through to word.
    function automatic lane_fmt_t format_store(input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic [31:0] data);
        lane_fmt_t f;
        case (size)
            2'b00: begin
                f.wdata = {4{data[7:0]}};
                f.be    = 4'b0001 << lane;
            end
            2'b01: begin
                f.wdata = {2{data[15:0]}};
                f.be    = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                f.wdata = data;
                f.be    = 4'b1111;
            end
        endcase
        return f;
    endfunction

    logic [29:0]   mem_addr_q  [DEPTH];
    logic [31:0]   mem_wdata_q [DEPTH];
    logic [3:0]    mem_be_q    [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_s;
    logic          pop_s;
    logic          enq_s;
    logic [1:0]    lane_s;
    logic [29:0]   word_addr_s;
    lane_fmt_t     fmt_s;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != CW'(0));
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    assign out_addr  = {mem_addr_q[rd_ptr_q], 2'b00};
    assign out_wdata = mem_wdata_q[rd_ptr_q];
    assign out_be    = mem_be_q[rd_ptr_q];

    // Byte lane used for formatting: rounded down to the access size, which is
    // a no-op for aligned stores and the required rounding when not trapping.
    always_comb begin
        lane_s = 2'b00;
        case (in_size)
            2'b00:   lane_s = in_addr[1:0];
            2'b01:   lane_s = {in_addr[1], 1'b0};
            default: lane_s = 2'b00;
        endcase
        word_addr_s = in_addr[31:2];
        fmt_s       = format_store(in_size, lane_s, in_data);
    end

`ifdef STORE_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lane);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = lane[0];
            2'b10:   m = (lane != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    logic        trap_s;
    logic        misalign_q, misalign_d;
    logic [31:0] misalign_addr_q, misalign_addr_d;

    assign trap_s        = push_s && is_misaligned(in_size, in_addr[1:0]);
    assign enq_s         = push_s && !trap_s;
    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;

    // Next-state of the trap report; a flush drops the trapped request too.
    always_comb begin
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        if (trap_s && !flush) begin
            misalign_d      = 1'b1;
            misalign_addr_d = in_addr;
        end else begin
            misalign_d      = 1'b0;
        end
    end

    // Trap report registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= 32'h0000_0000;
        end else begin
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end
`else
    assign enq_s         = push_s;
    assign misalign      = 1'b0;
    assign misalign_addr = 32'h0000_0000;
`endif

    // Pointer and occupancy next-state; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = PW'(0);
            rd_ptr_d = PW'(0);
            count_d  = CW'(0);
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head outputs read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_q[i]  <= 30'h0;
                mem_wdata_q[i] <= 32'h0000_0000;
                mem_be_q[i]    <= 4'b0000;
            end
        end else if (enq_s && !flush) begin
            mem_addr_q[wr_ptr_q]  <= word_addr_s;
            mem_wdata_q[wr_ptr_q] <= fmt_s.wdata;
            mem_be_q[wr_ptr_q]    <= fmt_s.be;
        end
    end

endmodule

// File: tb/tb_store_narrow.sv
module tb_store_narrow;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_data = 32'h0;
    logic [1:0]  in_size = 2'b00;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;
    logic [31:0] out_wdata;
    logic [3:0]  out_be;
    logic        misalign;
    logic [31:0] misalign_addr;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_maddr = 32'h0;

    store_narrow #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_size(in_size), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_wdata(out_wdata), .out_be(out_be), .misalign(misalign),
        .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        trap;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        in_size  = s;
    endtask

    initial begin
        // Aligned cases
        vecs[0] = '{32'h0000_1003, 32'h0000_00AB, 2'b00, 1'b0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
        vecs[1] = '{32'h0000_1000, 32'h1234_56CD, 2'b00, 1'b0, 32'h0000_1000, 32'hCDCD_CDCD, 4'b0001};
        vecs[2] = '{32'h0000_1001, 32'h0000_0055, 2'b00, 1'b0, 32'h0000_1000, 32'h5555_5555, 4'b0010};
        vecs[3] = '{32'h0000_2002, 32'h1234_CDEF, 2'b01, 1'b0, 32'h0000_2000, 32'hCDEF_CDEF, 4'b1100};
        vecs[4] = '{32'h0000_2000, 32'hFFFF_0102, 2'b01, 1'b0, 32'h0000_2000, 32'h0102_0102, 4'b0011};
        vecs[5] = '{32'h0000_2004, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0000_2004, 32'hDEAD_BEEF, 4'b1111};
`ifdef STORE_MISALIGN_TRAP_EN
        vecs[6] = '{32'h0000_3001, 32'hCAFE_F00D, 2'b10, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[7] = '{32'h0000_4003, 32'h0000_BEEF, 2'b01, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[8] = '{32'h0000_5006, 32'h0123_4567, 2'b11, 1'b1, 32'h0, 32'h0, 4'b0000};
`else
        vecs[6] = '{32'h0000_3001, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0000_3000, 32'hCAFE_F00D, 4'b1111};
        vecs[7] = '{32'h0000_4003, 32'h0000_BEEF, 2'b01, 1'b0, 32'h0000_4000, 32'hBEEF_BEEF, 4'b1100};
        vecs[8] = '{32'h0000_5006, 32'h0123_4567, 2'b11, 1'b0, 32'h0000_5004, 32'h0123_4567, 4'b1111};
`endif

        // Reset state
        tick();
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_in_ready", in_ready, 32'd1);
        check("rst_misalign", misalign, 32'd0);
        check("rst_misalign_addr", misalign_addr, 32'h0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_out_wdata", out_wdata, 32'h0);
        check("rst_out_be", out_be, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single-store vectors
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].addr, vecs[i].data, vecs[i].size);
            out_ready = 1'b0;
            check("vec_in_ready", in_ready, 32'd1);
            tick();
            drive(1'b0, 32'h0, 32'h0, 2'b00);
            if (vecs[i].trap) exp_maddr = vecs[i].addr;
            check("vec_misalign", misalign, {31'd0, vecs[i].trap});
            check("vec_out_valid", out_valid, {31'd0, !vecs[i].trap});
            check("vec_misalign_addr", misalign_addr, exp_maddr);
            if (!vecs[i].trap) begin
                check("vec_out_addr", out_addr, vecs[i].e_addr);
                check("vec_out_wdata", out_wdata, vecs[i].e_wdata);
                check("vec_out_be", out_be, {28'd0, vecs[i].e_be});
            end
            tick();
            check("vec_misalign_end", misalign, 32'd0);
            check("vec_hold_valid", out_valid, {31'd0, !vecs[i].trap});
            if (!vecs[i].trap) check("vec_hold_wdata", out_wdata, vecs[i].e_wdata);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("vec_popped", out_valid, 32'd0);
        end

        // Backpressure: fill, stall third, single pop, order preserved
        drive(1'b1, 32'h100, 32'h1111_1111, 2'b10);
        tick();
        drive(1'b1, 32'h104, 32'h2222_2222, 2'b10);
        tick();
        check("full_in_ready", in_ready, 32'd0);
        check("full_head", out_addr, 32'h100);
        drive(1'b1, 32'h108, 32'h3333_3333, 2'b10);
        tick();
        check("stall_in_ready", in_ready, 32'd0);
        check("stall_head", out_addr, 32'h100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("after_pop_in_ready", in_ready, 32'd1);
        check("after_pop_head", out_addr, 32'h104);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("refill_in_ready", in_ready, 32'd0);
        out_ready = 1'b1;
        tick();
        check("order_addr", out_addr, 32'h108);
        check("order_wdata", out_wdata, 32'h3333_3333);
        tick();
        out_ready = 1'b0;
        check("drained", out_valid, 32'd0);

        // Simultaneous push and pop with one entry buffered
        drive(1'b1, 32'h200, 32'hAAAA_0001, 2'b10);
        tick();
        drive(1'b1, 32'h204, 32'hAAAA_0002, 2'b10);
        out_ready = 1'b1;
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        out_ready = 1'b0;
        check("pp_valid", out_valid, 32'd1);
        check("pp_head", out_addr, 32'h204);
        check("pp_in_ready", in_ready, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_drained", out_valid, 32'd0);

        // Flush with two entries buffered and a same-cycle push
        drive(1'b1, 32'h300, 32'h0, 2'b10);
        tick();
        drive(1'b1, 32'h304, 32'h0, 2'b10);
        tick();
        drive(1'b1, 32'h308, 32'h0, 2'b10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("flush_valid", out_valid, 32'd0);
        check("flush_in_ready", in_ready, 32'd1);
        tick();
        check("flush_no_push", out_valid, 32'd0);

        // Flush with one entry while a push is accepted: push dropped
        drive(1'b1, 32'h400, 32'h0, 2'b10);
        tick();
        drive(1'b1, 32'h404, 32'h0, 2'b10);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("flush2_valid", out_valid, 32'd0);
        drive(1'b1, 32'h408, 32'h5A5A_5A5A, 2'b10);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("post_flush_addr", out_addr, 32'h408);
        check("post_flush_wdata", out_wdata, 32'h5A5A_5A5A);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset mid-cycle with a full buffer
        drive(1'b1, 32'h500, 32'h0, 2'b10);
        tick();
        drive(1'b1, 32'h504, 32'h0, 2'b10);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("pre_rst_full", in_ready, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 32'd0);
        check("arst_in_ready", in_ready, 32'd1);
        check("arst_out_addr", out_addr, 32'h0);
        check("arst_misalign_addr", misalign_addr, 32'h0);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 32'h600, 32'h0000_0077, 2'b00);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("post_rst_valid", out_valid, 32'd1);
        check("post_rst_addr", out_addr, 32'h600);
        check("post_rst_be", out_be, 32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_rst_drained", out_valid, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
